// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MULT/DIV latency model owning HI/LO, with F/D stall request
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        md_use,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;
   logic [7:0] cnt, cnt_n;
   logic [31:0] hi_nxt, lo_nxt, hi_nxt_n, lo_nxt_n, hi_n, lo_n;
   logic dz, dz_n;
   logic sgn;
   logic [63:0] prod;
   logic [31:0] a_abs, b_abs, q_abs, r_abs, quo, rem;
   assign busy  = (state == RUN);
   assign stall = md_use & (busy | (start & (md_op <= 3'd3)));
   always_comb begin
      sgn   = ~md_op[0];
      prod  = {{32{sgn & rs_val[31]}}, rs_val} * {{32{sgn & rt_val[31]}}, rt_val};
      a_abs = (sgn & rs_val[31]) ? -rs_val : rs_val;
      b_abs = (sgn & rt_val[31]) ? -rt_val : rt_val;
      q_abs = (b_abs == 32'd0) ? 32'd0 : a_abs / b_abs;
      r_abs = (b_abs == 32'd0) ? 32'd0 : a_abs % b_abs;
      quo   = (sgn & (rs_val[31] ^ rt_val[31])) ? -q_abs : q_abs;
      rem   = (sgn & rs_val[31]) ? -r_abs : r_abs;
   end
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      hi_nxt_n = hi_nxt;
      lo_nxt_n = lo_nxt;
      dz_n     = dz;
      hi_n     = hi;
      lo_n     = lo;
      if (state == RUN) begin
         cnt_n = cnt - 8'd1;
         if (cnt == 8'd1) begin
            state_n = IDLE;
            hi_n    = dz ? hi : hi_nxt;
            lo_n    = dz ? lo : lo_nxt;
         end
      end else if (start) begin
         if (md_op <= 3'd1) begin
            {hi_nxt_n, lo_nxt_n} = prod;
            dz_n    = 1'b0;
            cnt_n   = 8'(MULT_CYCLES);
            state_n = RUN;
         end else if (md_op <= 3'd3) begin
            hi_nxt_n = rem;
            lo_nxt_n = quo;
            dz_n     = (rt_val == 32'd0);
            cnt_n    = 8'(DIV_CYCLES);
            state_n  = RUN;
         end else if (md_op == 3'd4) begin
            hi_n = rs_val;
         end else if (md_op == 3'd5) begin
            lo_n = rs_val;
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         hi_nxt <= '0;
         lo_nxt <= '0;
         dz     <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         hi_nxt <= hi_nxt_n;
         lo_nxt <= lo_nxt_n;
         dz     <= dz_n;
         hi     <= hi_n;
         lo     <= lo_n;
      end
   end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed plus random stimulus against an arithmetic reference model
module tb_mdu_ctrl;
   localparam int MC = 5;
   localparam int DC = 10;
   logic clk = 0, reset = 1, start = 0, md_use = 0;
   logic [2:0] md_op = 3'd7;
   logic [31:0] rs_val = 0, rt_val = 0;
   logic busy, stall;
   logic [31:0] hi, lo;
   int total = 0, bad = 0;
   logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
   int m_left = 0;
   bit m_dz = 0;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op), .rs_val(rs_val),
      .rt_val(rt_val), .md_use(md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p, ua, ub;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && !m_dz) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         ua = {32'd0, a};
         ub = {32'd0, b};
         if (op == 0) begin
            p = 64'(sa * sb);
            {m_phi, m_plo} = p;
            m_dz = 0;
            m_left = MC;
         end else if (op == 1) begin
            p = ua * ub;
            {m_phi, m_plo} = p;
            m_dz = 0;
            m_left = MC;
         end else if (op == 2 || op == 3) begin
            m_dz = (b == 0);
            m_left = DC;
            if (!m_dz) begin
               q = (op == 2) ? sa / sb : longint'(ua / ub);
               r = (op == 2) ? sa % sb : longint'(ua % ub);
               m_plo = q[31:0];
               m_phi = r[31:0];
            end
         end else if (op == 4) m_hi = a;
         else if (op == 5) m_lo = a;
      end
   endtask

   task automatic cycle(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic u);
      @(negedge clk);
      start = s; md_op = op; rs_val = a; rt_val = b; md_use = u;
      #1;
      chk("stall", {31'd0, stall}, {31'd0, u & ((m_left > 0) | (s & (op <= 3)))});
      model_edge(s, op, a, b);
      @(posedge clk);
      #1;
      chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
   endtask

   task automatic idle(input int n, input logic u);
      for (int i = 0; i < n; i++) cycle(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, u);
   endtask

   function automatic logic [31:0] rv();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'($urandom_range(0, 20));
         4: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 0;

      cycle(1, 3'd0, 32'hFFFFFFFD, 32'd5, 1);
      idle(MC, 1);
      cycle(0, 3'd7, 0, 0, 1);
      chk("mult_hi", hi, 32'hFFFFFFFF);
      chk("mult_lo", lo, 32'hFFFFFFF1);

      cycle(1, 3'd1, 32'hFFFFFFFF, 32'd2, 0);
      idle(MC, 0);
      chk("multu_hi", hi, 32'h00000001);
      chk("multu_lo", lo, 32'hFFFFFFFE);

      cycle(1, 3'd2, 32'hFFFFFFF9, 32'd2, 0);
      idle(DC, 0);
      chk("div_hi", hi, 32'hFFFFFFFF);
      chk("div_lo", lo, 32'hFFFFFFFD);

      cycle(1, 3'd3, 32'd7, 32'd2, 0);
      idle(DC, 0);
      chk("divu_hi", hi, 32'd1);
      chk("divu_lo", lo, 32'd3);

      cycle(1, 3'd4, 32'h11, 0, 0);
      cycle(1, 3'd5, 32'h22, 0, 0);
      cycle(1, 3'd2, 32'd1234, 32'd0, 0);
      idle(DC, 0);
      chk("dz_hi", hi, 32'h11);
      chk("dz_lo", lo, 32'h22);

      cycle(1, 3'd2, 32'd100, 32'd7, 0);
      idle(2, 0);
      cycle(1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      idle(DC - 3, 0);
      chk("ign_hi", hi, 32'd2);
      chk("ign_lo", lo, 32'd14);

      cycle(1, 3'd4, 32'hABCD0000, 0, 0);
      chk("mthi", hi, 32'hABCD0000);

      cycle(1, 3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
      idle(DC, 0);
      chk("ovf_hi", hi, 32'd0);
      chk("ovf_lo", lo, 32'h80000000);

      cycle(1, 3'd2, 32'd500, 32'd3, 1);
      idle(3, 1);
      #2;
      reset = 1;
      #1;
      chk("ar_busy", {31'd0, busy}, 32'd0);
      chk("ar_stall", {31'd0, stall}, 32'd0);
      chk("ar_hi", hi, 32'd0);
      chk("ar_lo", lo, 32'd0);
      m_hi = 0; m_lo = 0; m_left = 0; m_dz = 0;
      @(negedge clk);
      reset = 0;
      idle(DC, 0);
      cycle(1, 3'd0, 32'd6, 32'd7, 0);
      idle(MC, 0);
      chk("post_rst_lo", lo, 32'd42);
      chk("post_rst_hi", hi, 32'd0);

      for (int i = 0; i < 600; i++)
         cycle(1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), rv(), rv(), 1'($urandom_range(0, 1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
